// File: rtl/perf_event_counters.sv
// Performance event counter bank: per-channel event counters plus a cycle counter,
// freeze-on-halt, sticky overflow flags and a registered one-cycle read port.
module perf_event_counters #(
    parameter int NUM_EVT  = 5,
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b0,
    parameter int IDX_W    = $clog2(NUM_EVT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               count_en,
    input  logic               halt,
    input  logic               clr,
    input  logic               rd_req,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic [CNT_W-1:0]   rd_data,
    output logic [NUM_EVT:0]   ovf,
    output logic               frozen
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_frozen;
    logic [NUM_EVT:0]   r_ovf;
    logic [CNT_W-1:0]   r_cnt [NUM_EVT+1];
    logic               r_rd_valid;
    logic [CNT_W-1:0]   r_rd_data;

    logic               w_count;
    logic [NUM_EVT:0]   w_inc;
    logic [CNT_W:0]     w_next [NUM_EVT+1];
    logic [CNT_W-1:0]   w_rd_sel;

    // Returns {overflow, next_value}; overflow means all-ones plus an increment.
    function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v, input logic inc);
        logic [CNT_W:0] res;
        if (inc && (&v)) begin
            res = {1'b1, (SATURATE ? v : {CNT_W{1'b0}})};
        end else begin
            res = {1'b0, v + {{(CNT_W-1){1'b0}}, inc}};
        end
        return res;
    endfunction

    // Increment vector: the cycle counter sits at index NUM_EVT.
    always_comb begin
        w_count = (r_state == ST_RUN) && count_en;
        w_inc   = {w_count, evt & {NUM_EVT{w_count}}};
    end

    // Next value and overflow bit of every counter.
    always_comb begin
        for (int i = 0; i <= NUM_EVT; i++) begin
            w_next[i] = bump(r_cnt[i], w_inc[i]);
        end
    end

    // Read mux; indices beyond the cycle counter match nothing and read zero.
    always_comb begin
        w_rd_sel = {CNT_W{1'b0}};
        for (int i = 0; i <= NUM_EVT; i++) begin
            w_rd_sel = w_rd_sel | ((rd_idx == IDX_W'(i)) ? r_cnt[i] : {CNT_W{1'b0}});
        end
    end

    // Counters, overflow flags and the RUN/FROZEN state machine; clr outranks halt and events.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_state  <= ST_RUN;
            r_frozen <= 1'b0;
            r_ovf    <= {(NUM_EVT+1){1'b0}};
            for (int i = 0; i <= NUM_EVT; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i <= NUM_EVT; i++) begin
                r_cnt[i] <= w_next[i][CNT_W-1:0];
                r_ovf[i] <= r_ovf[i] | w_next[i][CNT_W];
            end
            case (r_state)
                ST_RUN: begin
                    if (halt) begin
                        r_state  <= ST_FROZEN;
                        r_frozen <= 1'b1;
                    end else begin
                        r_state  <= ST_RUN;
                        r_frozen <= 1'b0;
                    end
                end
                ST_FROZEN: begin
                    r_state  <= ST_FROZEN;
                    r_frozen <= 1'b1;
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_frozen <= 1'b0;
                end
            endcase
        end
    end

    // Read port samples pre-update counter values, so a read in a clr cycle sees the old count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= {CNT_W{1'b0}};
        end else begin
            r_rd_valid <= rd_req;
            if (rd_req) begin
                r_rd_data <= w_rd_sel;
            end else begin
                r_rd_data <= r_rd_data;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign ovf      = r_ovf;
    assign frozen   = r_frozen;

endmodule

// File: tb/tb_perf_event_counters.sv
// Self-checking bench for perf_event_counters: a reference model pushes expected read
// data into a queue when a read is driven; each test pops and compares after the edge.
module tb_perf_event_counters;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, count_en, halt, clr, rd_req;
    logic [4:0]  evt;
    logic [2:0]  rd_idx;
    logic        rd_valid, frozen;
    logic [31:0] rd_data;
    logic [5:0]  ovf;

    logic        s_clr, s_rd_req, s_halt;
    logic [4:0]  s_evt;
    logic [2:0]  s_rd_idx;
    logic        w_rd_valid, w_frozen, t_rd_valid, t_frozen;
    logic [3:0]  w_rd_data, t_rd_data;
    logic [5:0]  w_ovf, t_ovf;

    perf_event_counters dut (
        .clk(clk), .rst(rst), .evt(evt), .count_en(count_en), .halt(halt), .clr(clr),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data),
        .ovf(ovf), .frozen(frozen)
    );

    perf_event_counters #(.CNT_W(4), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .evt(s_evt), .count_en(count_en), .halt(s_halt), .clr(s_clr),
        .rd_req(s_rd_req), .rd_idx(s_rd_idx), .rd_valid(w_rd_valid), .rd_data(w_rd_data),
        .ovf(w_ovf), .frozen(w_frozen)
    );

    perf_event_counters #(.CNT_W(4), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .evt(s_evt), .count_en(count_en), .halt(s_halt), .clr(s_clr),
        .rd_req(s_rd_req), .rd_idx(s_rd_idx), .rd_valid(t_rd_valid), .rd_data(t_rd_data),
        .ovf(t_ovf), .frozen(t_frozen)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] m_cnt [6];
    logic        m_frozen;
    logic [31:0] q [$];
    logic [31:0] exp_v;

    // Advance the model using the inputs present before the edge, then step one clock.
    task automatic tick();
        if (!rst) begin
            for (int i = 0; i < 6; i++) m_cnt[i] = 32'd0;
            m_frozen = 1'b0;
        end else begin
            if (rd_req) q.push_back((rd_idx <= 3'd5) ? m_cnt[int'(rd_idx)] : 32'd0);
            if (clr) begin
                for (int i = 0; i < 6; i++) m_cnt[i] = 32'd0;
                m_frozen = 1'b0;
            end else if (!m_frozen) begin
                if (count_en) begin
                    for (int i = 0; i < 5; i++) m_cnt[i] = m_cnt[i] + {31'd0, evt[i]};
                    m_cnt[5] = m_cnt[5] + 32'd1;
                end
                if (halt) m_frozen = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pop_exp();
        if (q.size() == 0) return 32'hFFFF_FFFF;
        return q.pop_front();
    endfunction

    task automatic test_reset();
        rst = 1'b0; count_en = 1'b0; halt = 1'b0; clr = 1'b0; rd_req = 1'b0;
        evt = 5'd0; rd_idx = 3'd0;
        s_clr = 1'b0; s_rd_req = 1'b0; s_halt = 1'b0; s_evt = 5'd0; s_rd_idx = 3'd0;
        repeat (3) tick();
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_data !== 32'd0 || frozen !== 1'b0 || ovf !== 6'd0) begin
            $display("FAIL reset_state: got valid=%b data=%0d frozen=%b ovf=%b, want 0/0/0/0",
                     rd_valid, rd_data, frozen, ovf);
            n_fail++;
        end
        rst = 1'b1;
        rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd_idx = 3'(i);
            tick();
            exp_v = pop_exp();
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
                $display("FAIL idle_read idx=%0d: got valid=%b data=%0d, want 1/%0d", i, rd_valid, rd_data, exp_v);
                n_fail++;
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_basic_count();
        count_en = 1'b1;
        evt = 5'b00011;
        repeat (10) tick();
        evt = 5'd0;
        repeat (5) tick();
        count_en = 1'b0;
        rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd_idx = 3'(i);
            tick();
            exp_v = pop_exp();
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
                $display("FAIL basic_count idx=%0d: got valid=%b data=%0d, want 1/%0d", i, rd_valid, rd_data, exp_v);
                n_fail++;
            end
        end
        rd_req = 1'b0;
        tick();
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_data !== m_cnt[5]) begin
            $display("FAIL read_hold: got valid=%b data=%0d, want 0/%0d", rd_valid, rd_data, m_cnt[5]);
            n_fail++;
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        count_en = 1'b1;
        evt = 5'b00001;
        rd_req = 1'b1;
        rd_idx = 3'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_v = pop_exp();
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
                $display("FAIL back_to_back k=%0d: got valid=%b data=%0d, want 1/%0d", k, rd_valid, rd_data, exp_v);
                n_fail++;
            end
        end
        rd_req = 1'b0; count_en = 1'b0; evt = 5'd0;
        tick();
    endtask

    task automatic test_halt_freeze();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        count_en = 1'b1;
        evt = 5'b00001;
        repeat (6) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        n_cmp++;
        if (frozen !== 1'b1) begin
            $display("FAIL halt_frozen_rise: got %b, want 1", frozen);
            n_fail++;
        end
        repeat (20) tick();
        evt = 5'd0; count_en = 1'b0;
        rd_req = 1'b1;
        for (int i = 0; i < 6; i += 5) begin
            rd_idx = 3'(i);
            tick();
            exp_v = pop_exp();
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== exp_v || rd_data !== 32'd7) begin
                $display("FAIL halt_count idx=%0d: got valid=%b data=%0d, want 1/%0d", i, rd_valid, rd_data, exp_v);
                n_fail++;
            end
        end
        rd_req = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++;
        if (frozen !== 1'b0) begin
            $display("FAIL clr_unfreeze: got %b, want 0", frozen);
            n_fail++;
        end
        rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd_idx = 3'(i);
            tick();
            exp_v = pop_exp();
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
                $display("FAIL halt_clr_read idx=%0d: got valid=%b data=%0d, want 1/%0d", i, rd_valid, rd_data, exp_v);
                n_fail++;
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_overflow();
        int n_ev;
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        count_en = 1'b1;
        n_ev = 0;
        for (int phase = 0; phase < 2; phase++) begin
            s_evt = 5'b00100;
            repeat ((phase == 0) ? 15 : 2) begin
                tick();
                n_ev++;
            end
            s_evt = 5'd0;
            s_rd_req = 1'b1;
            s_rd_idx = 3'd2;
            tick();
            s_rd_req = 1'b0;
            n_cmp++;
            if (w_rd_valid !== 1'b1 || w_rd_data !== 4'(n_ev % 16) || w_ovf[2] !== (n_ev > 15)) begin
                $display("FAIL ovf_wrap events=%0d: got data=%0d ovf2=%b, want %0d/%b",
                         n_ev, w_rd_data, w_ovf[2], n_ev % 16, n_ev > 15);
                n_fail++;
            end
            n_cmp++;
            if (t_rd_valid !== 1'b1 || t_rd_data !== ((n_ev > 15) ? 4'd15 : 4'(n_ev)) || t_ovf[2] !== (n_ev > 15)) begin
                $display("FAIL ovf_sat events=%0d: got data=%0d ovf2=%b, want %0d/%b",
                         n_ev, t_rd_data, t_ovf[2], (n_ev > 15) ? 15 : n_ev, n_ev > 15);
                n_fail++;
            end
        end
        count_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        count_en = 1'b1;
        evt = 5'b00001;
        repeat (9) tick();
        evt = 5'd0; count_en = 1'b0;
        clr = 1'b1; halt = 1'b1; evt = 5'b11111; count_en = 1'b1;
        rd_req = 1'b1; rd_idx = 3'd0;
        tick();
        clr = 1'b0; halt = 1'b0; evt = 5'd0; count_en = 1'b0;
        exp_v = pop_exp();
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== exp_v || rd_data !== 32'd9) begin
            $display("FAIL simul_preclear_read: got valid=%b data=%0d, want 1/%0d", rd_valid, rd_data, exp_v);
            n_fail++;
        end
        n_cmp++;
        if (frozen !== 1'b0 || ovf !== 6'd0) begin
            $display("FAIL simul_state: got frozen=%b ovf=%b, want 0/0", frozen, ovf);
            n_fail++;
        end
        for (int i = 0; i < 6; i++) begin
            rd_idx = 3'(i);
            tick();
            exp_v = pop_exp();
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
                $display("FAIL simul_cleared idx=%0d: got valid=%b data=%0d, want 1/%0d", i, rd_valid, rd_data, exp_v);
                n_fail++;
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        count_en = 1'b1;
        evt = 5'b00010;
        repeat (3) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0; evt = 5'd0; count_en = 1'b0;
        rd_req = 1'b1; rd_idx = 3'd1;
        tick();
        exp_v = pop_exp();
        n_cmp++;
        if (frozen !== 1'b1 || rd_valid !== 1'b1 || rd_data !== exp_v) begin
            $display("FAIL pre_reset_read: got frozen=%b valid=%b data=%0d, want 1/1/%0d", frozen, rd_valid, rd_data, exp_v);
            n_fail++;
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (rd_valid !== 1'b0 || frozen !== 1'b0 || rd_data !== 32'd0) begin
                $display("FAIL reset_mid k=%0d: got valid=%b frozen=%b data=%0d, want 0/0/0", k, rd_valid, frozen, rd_data);
                n_fail++;
            end
        end
        rst = 1'b1;
        for (int i = 6; i < 8; i++) begin
            rd_idx = 3'(i);
            tick();
            exp_v = pop_exp();
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
                $display("FAIL out_of_range idx=%0d: got valid=%b data=%0d, want 1/%0d", i, rd_valid, rd_data, exp_v);
                n_fail++;
            end
        end
        rd_req = 1'b0;
        tick();
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL valid_drop: got %b, want 0", rd_valid);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_back_to_back();
        test_halt_freeze();
        test_overflow();
        test_simultaneous();
        test_reset_mid();
        n_cmp++;
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
            n_fail++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
